// File: rtl/matmul_sequencer.sv
// matmul_sequencer: job sequencer for a 3x3 matrix multiply datapath.
// Streams W then X elements into a memory bank, then runs three
// unload/accumulate phases and pulses done.
// Optional build macro GO_GATE_EN: inserts an ARMED state that holds
// after the load until the go input is seen.
module matmul_sequencer #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned N_ELEM    = 9,
    parameter int unsigned PHASE_LEN = 2
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              load_req,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              go,
    output logic [DATA_W-1:0] mem_data,
    output logic              load_w,
    output logic              load_x,
    output logic              mem_clear,
    output logic              unload1,
    output logic              unload2,
    output logic              unload3,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W      = 4;
    localparam logic [CNT_W-1:0] ELEM_LAST  = CNT_W'(N_ELEM - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_X,
`ifdef GO_GATE_EN
        S_ARMED,
`endif
        S_UNLOAD1,
        S_UNLOAD2,
        S_UNLOAD3,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] elem_q, elem_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic             mem_clear_q, mem_clear_d;
    logic             unload1_q, unload1_d;
    logic             unload2_q, unload2_d;
    logic             unload3_q, unload3_d;
    logic             acc_clr_q, acc_clr_d;
    logic             acc_en_q, acc_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             in_unload_d;

`ifndef GO_GATE_EN
    // go has no function without the ARMED state
    logic go_unused;
    assign go_unused = go;
`endif

    // Stream handshake and memory write strobes follow the registered state
    assign in_ready = (state_q == S_LOAD_W) || (state_q == S_LOAD_X);
    assign accept   = in_valid && in_ready;
    assign load_w   = (state_q == S_LOAD_W) && in_valid;
    assign load_x   = (state_q == S_LOAD_X) && in_valid;
    assign mem_data = in_data;

    // Next state, counters and next values of the registered outputs
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        phase_d     = phase_q;
        mem_clear_d = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            elem_d  = '0;
            phase_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_req) begin
                        state_d     = S_LOAD_W;
                        elem_d      = '0;
                        mem_clear_d = 1'b1;
                    end
                end
                S_LOAD_W: begin
                    if (accept) begin
                        if (elem_q == ELEM_LAST) begin
                            elem_d  = '0;
                            state_d = S_LOAD_X;
                        end else begin
                            elem_d = elem_q + CNT_W'(1);
                        end
                    end
                end
                S_LOAD_X: begin
                    if (accept) begin
                        if (elem_q == ELEM_LAST) begin
                            elem_d  = '0;
                            phase_d = '0;
`ifdef GO_GATE_EN
                            state_d = S_ARMED;
`else
                            state_d = S_UNLOAD1;
`endif
                        end else begin
                            elem_d = elem_q + CNT_W'(1);
                        end
                    end
                end
`ifdef GO_GATE_EN
                S_ARMED: begin
                    if (go) begin
                        phase_d = '0;
                        state_d = S_UNLOAD1;
                    end
                end
`endif
                S_UNLOAD1, S_UNLOAD2, S_UNLOAD3: begin
                    if (phase_q == PHASE_LAST) begin
                        phase_d = '0;
                        case (state_q)
                            S_UNLOAD1: state_d = S_UNLOAD2;
                            S_UNLOAD2: state_d = S_UNLOAD3;
                            default:   state_d = S_DONE;
                        endcase
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        in_unload_d = (state_d == S_UNLOAD1) || (state_d == S_UNLOAD2) ||
                      (state_d == S_UNLOAD3);
        unload1_d   = (state_d == S_UNLOAD1);
        unload2_d   = (state_d == S_UNLOAD2);
        unload3_d   = (state_d == S_UNLOAD3);
        acc_clr_d   = (state_d == S_UNLOAD1) && (phase_d == '0);
        acc_en_d    = in_unload_d && (phase_d == PHASE_LAST);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State, counters and output registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            phase_q     <= '0;
            mem_clear_q <= 1'b0;
            unload1_q   <= 1'b0;
            unload2_q   <= 1'b0;
            unload3_q   <= 1'b0;
            acc_clr_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            phase_q     <= phase_d;
            mem_clear_q <= mem_clear_d;
            unload1_q   <= unload1_d;
            unload2_q   <= unload2_d;
            unload3_q   <= unload3_d;
            acc_clr_q   <= acc_clr_d;
            acc_en_q    <= acc_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_clear = mem_clear_q;
    assign unload1   = unload1_q;
    assign unload2   = unload2_q;
    assign unload3   = unload3_q;
    assign acc_clr   = acc_clr_q;
    assign acc_en    = acc_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: job-level reference model checked every cycle,
// plus directed scenarios with hand-computed tallies.
module tb_matmul_sequencer;

    localparam int DW  = 4;
    localparam int N   = 9;
    localparam int PL  = 2;
    localparam int LEN = 2 * N;
    localparam int UL  = 3 * PL;
`ifdef GO_GATE_EN
    localparam int DONE_LAG = 8;
`else
    localparam int DONE_LAG = 7;
`endif

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic          load_req = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          go = 1'b0;
    logic          in_ready, load_w, load_x, mem_clear;
    logic          unload1, unload2, unload3, acc_clr, acc_en, busy, done;
    logic [DW-1:0] mem_data;

    matmul_sequencer #(.DATA_W(DW), .N_ELEM(N), .PHASE_LEN(PL)) dut (
        .clk(clk), .clear_n(clear_n), .load_req(load_req), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .go(go),
        .mem_data(mem_data), .load_w(load_w), .load_x(load_x),
        .mem_clear(mem_clear), .unload1(unload1), .unload2(unload2),
        .unload3(unload3), .acc_clr(acc_clr), .acc_en(acc_en), .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Job model: beats accepted so far, and cycle index into the unload sequence
    bit m_active, m_armed, m_first;
    int m_beats, m_u;

    // Tallies over the current scenario
    int n_lw, n_lx, n_mc, n_u1, n_u2, n_u3, n_aclr, n_aen, n_done;
    int last_x_cyc, done_cyc;
    int got_q[$];
    int exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model update
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_active = 0; m_armed = 0; m_first = 0; m_beats = 0; m_u = -1;
        end else if (abort) begin
            m_active = 0; m_armed = 0; m_first = 0; m_beats = 0; m_u = -1;
        end else if (!m_active) begin
            if (load_req) begin
                m_active = 1; m_armed = 0; m_first = 1; m_beats = 0; m_u = -1;
            end
        end else begin
            m_first = 0;
            if (m_u >= 0) begin
                if (m_u == UL) begin
                    m_active = 0; m_u = -1; m_beats = 0;
                end else begin
                    m_u++;
                end
            end else if (m_armed) begin
                if (go) begin
                    m_armed = 0; m_u = 0;
                end
            end else if (in_valid) begin
                m_beats++;
                if (m_beats == LEN) begin
`ifdef GO_GATE_EN
                    m_armed = 1;
`else
                    m_u = 0;
`endif
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            bit ir, lw, lx, u1, u2, u3, ac, ae, dn;
            logic [10:0] expv, actv;
            ir = m_active && m_u < 0 && !m_armed && m_beats < LEN;
            lw = ir && in_valid && m_beats < N;
            lx = ir && in_valid && m_beats >= N;
            u1 = m_u >= 0 && m_u < PL;
            u2 = m_u >= PL && m_u < 2 * PL;
            u3 = m_u >= 2 * PL && m_u < UL;
            ac = (m_u == 0);
            ae = m_u >= 0 && m_u < UL && (m_u % PL) == PL - 1;
            dn = (m_u == UL);
            expv = {ir, lw, lx, m_first, u1, u2, u3, ac, ae, m_active, dn};
            actv = {in_ready, load_w, load_x, mem_clear, unload1, unload2,
                    unload3, acc_clr, acc_en, busy, done};
            n_assert++;
            if (actv !== expv) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got %b expected %b", cyc, actv, expv);
            end
            n_assert++;
            if (mem_data !== in_data) begin
                n_fail++;
                $display("FAIL mem_data cycle %0d: got %0d expected %0d", cyc, mem_data, in_data);
            end
            n_assert++;
            if ($countones({load_w, load_x, unload1, unload2, unload3}) > 1) begin
                n_fail++;
                $display("FAIL onehot cycle %0d: got %b expected at most one set", cyc,
                         {load_w, load_x, unload1, unload2, unload3});
            end
            if (load_w) begin n_lw++; got_q.push_back(int'(mem_data)); end
            if (load_x) begin n_lx++; got_q.push_back(int'(mem_data)); last_x_cyc = cyc; end
            if (mem_clear) n_mc++;
            if (unload1) n_u1++;
            if (unload2) n_u2++;
            if (unload3) n_u3++;
            if (acc_clr) n_aclr++;
            if (acc_en)  n_aen++;
            if (done) begin n_done++; done_cyc = cyc; end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_tally();
        n_lw = 0; n_lx = 0; n_mc = 0; n_u1 = 0; n_u2 = 0; n_u3 = 0;
        n_aclr = 0; n_aen = 0; n_done = 0; last_x_cyc = 0; done_cyc = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    // Pulse load_req from IDLE; returns in the first LOAD_W cycle
    task automatic start_job();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    // Stream beats first..last-1 of a job; seed 0 gives 1..9 then 9..1
    task automatic send(input int first, input int last, input int gap, input int seed);
        for (int i = first; i < last; i++) begin
            int d;
            d = (seed == 0) ? ((i < N) ? i + 1 : LEN - i) : ((i * seed + 3) % 16);
            exp_q.push_back(d);
            in_valid = 1'b1;
            in_data  = DW'(d);
            step();
            if (gap != 0) begin
                in_valid = 1'b0;
                step();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic fire_go();
`ifdef GO_GATE_EN
        go = 1'b1;
        step();
        go = 1'b0;
`endif
    endtask

    // Advance until done is observed; leaves the bench in the DONE cycle
    task automatic wait_done(input int max);
        int k = 0;
        while (!done && k < max) begin
            step();
            k++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic chk_rx();
        int errs = 0;
        chk("rx_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) errs++;
        chk("rx_data", errs, 0);
    endtask

    initial begin
        clr_tally();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_outs", int'({mem_clear, unload1, unload2, unload3, acc_clr, acc_en, done, in_ready}), 0);
        step();
        clear_n = 1'b1;
        step();

        // Back-to-back job
        clr_tally();
        start_job();
        send(0, LEN, 0, 0);
        fire_go();
        wait_done(40);
        step();
        chk("s1_mem_clear", n_mc, 1);
        chk("s1_load_w", n_lw, 9);
        chk("s1_load_x", n_lx, 9);
        chk("s1_unload1", n_u1, 2);
        chk("s1_unload2", n_u2, 2);
        chk("s1_unload3", n_u3, 2);
        chk("s1_acc_en", n_aen, 3);
        chk("s1_acc_clr", n_aclr, 1);
        chk("s1_done_lag", done_cyc - last_x_cyc, DONE_LAG);
        chk("s1_done_cnt", n_done, 1);
        chk_rx();
        chk("s1_idle", int'(busy), 0);

        // Stalled stream, in_valid every other cycle
        clr_tally();
        start_job();
        send(0, LEN, 1, 5);
        fire_go();
        wait_done(40);
        step();
        chk("s2_strobes", n_lw + n_lx, 18);
        chk("s2_acc_en", n_aen, 3);
        chk_rx();

        // Abort during 5th X beat, then a clean job
        clr_tally();
        start_job();
        send(0, N + 4, 0, 0);
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = DW'(5);
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("s3_busy", int'(busy), 0);
        chk("s3_in_ready", int'(in_ready), 0);
        repeat (6) step();
        chk("s3_no_done", n_done, 0);
        clr_tally();
        start_job();
        send(0, LEN, 0, 0);
        fire_go();
        wait_done(40);
        step();
        chk("s3_rejob_lw", n_lw, 9);
        chk("s3_rejob_done", n_done, 1);

        // Async reset during UNLOAD2
        clr_tally();
        start_job();
        send(0, LEN, 0, 0);
        fire_go();
        for (int k = 0; k < 20 && !unload2; k++) step();
        chk("s4_reach_u2", int'(unload2), 1);
        #2;
        clear_n = 1'b0;
        #1;
        chk("s4_all_zero", int'({in_ready, load_w, load_x, mem_clear, unload1, unload2,
                                 unload3, acc_clr, acc_en, busy, done}), 0);
        step();
        clear_n = 1'b1;
        repeat (8) step();
        chk("s4_no_done", n_done, 0);

`ifdef GO_GATE_EN
        // Gate holds in ARMED until go
        clr_tally();
        start_job();
        send(0, LEN, 0, 0);
        for (int k = 0; k < 10; k++) begin
            chk("s5_armed", int'({busy, unload1, unload2, unload3}), 8);
            step();
        end
        go = 1'b1;
        step();
        go = 1'b0;
        chk("s5_unload1", int'(unload1), 1);
        wait_done(20);
        step();
`endif

        // load_req during LOAD_W and during DONE is ignored
        clr_tally();
        start_job();
        send(0, 3, 0, 0);
        load_req = 1'b1;
        send(3, 4, 0, 0);
        load_req = 1'b0;
        send(4, LEN, 0, 0);
        fire_go();
        wait_done(40);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk("s6_idle", int'(busy), 0);
        repeat (3) step();
        chk("s6_still_idle", int'(busy), 0);
        chk("s6_mem_clear", n_mc, 1);
        chk("s6_strobes", n_lw + n_lx, 18);
        chk("s6_done", n_done, 1);
        chk_rx();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
